// File: rtl/julia_iter_ctrl.sv
// ---------------------------------------------------------------------------
// julia_iter_ctrl
//   Per-pixel iteration controller for the Julia-set datapath. It accepts one
//   pixel (z0, c) from the scanner and drives the single-step z^2+c engine
//   through its enable/done handshake. Each engine result is tested for
//   escape, and the controller reports how many steps were completed.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   px_start                   start a pixel (sampled only when idle)
//   px_x, px_y                 initial z, fixed-point (value = int/SCALE)
//   px_cr, px_ci               constant c, fixed-point
//   px_busy                    high whenever a pixel is in flight
//   px_done                    one-cycle pulse, result outputs valid
//   px_iter                    steps completed (held until next start)
//   px_escaped                 pixel escaped before MAX_ITER (held)
//   px_err                     engine failed to answer in time (held)
//   step_en                    engine enable
//   step_x, step_y             current z presented to the engine
//   step_cr, step_ci           latched c presented to the engine
//   step_done                  engine result valid
//   step_wx, step_wy           engine next z
//   step_res                   engine |w|^2, scaled by SCALE^2
// ---------------------------------------------------------------------------
module julia_iter_ctrl #(
    parameter int SCALE     = 1000,
    parameter int MAX_ITER  = 255,
    parameter int ITER_W    = 8,
    parameter int ESCAPE_TH = 4 * SCALE * SCALE,
    parameter int BOUND     = 2 * SCALE,
    parameter int TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                px_start,
    input  logic signed [31:0]  px_x,
    input  logic signed [31:0]  px_y,
    input  logic signed [31:0]  px_cr,
    input  logic signed [31:0]  px_ci,
    output logic                px_busy,
    output logic                px_done,
    output logic [ITER_W-1:0]   px_iter,
    output logic                px_escaped,
    output logic                px_err,
    output logic                step_en,
    output logic signed [31:0]  step_x,
    output logic signed [31:0]  step_y,
    output logic signed [31:0]  step_cr,
    output logic signed [31:0]  step_ci,
    input  logic                step_done,
    input  logic signed [31:0]  step_wx,
    input  logic signed [31:0]  step_wy,
    input  logic signed [31:0]  step_res
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);
    localparam logic signed [31:0] ESC_TH  = 32'(ESCAPE_TH);
    localparam logic signed [32:0] BOUND33 = 33'(BOUND);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t state, next_state;

    logic signed [31:0] z_x, z_y, c_r, c_i;
    logic signed [31:0] w_x, w_y, res;
    logic [ITER_W-1:0]  iter;
    logic [TMO_W-1:0]   tmo;
    logic               escaped, err;
    logic               escape;

    // Magnitude in 33 bits so that -2^31 yields +2^31 instead of wrapping.
    function automatic logic signed [32:0] abs33(input logic signed [31:0] v);
        logic signed [32:0] e;
        e = {v[31], v};
        return (e < 0) ? -e : e;
    endfunction

    // Negative res means the engine's square overflowed: treat as escaped.
    assign escape = (res > ESC_TH) || (res < 0) ||
                    (abs33(w_x) > BOUND33) || (abs33(w_y) > BOUND33);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        px_busy    = 1'b1;
        px_done    = 1'b0;
        step_en    = 1'b0;
        unique case (state)
            IDLE: begin
                px_busy = 1'b0;
                if (px_start) next_state = ISSUE;
            end
            ISSUE: begin
                step_en    = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                step_en = 1'b1;
                if (step_done)            next_state = CHECK;
                else if (tmo == TMO_LAST) next_state = DONE;
            end
            CHECK: begin
                // step_en stays low here so the engine can re-arm.
                if (escape || iter == ITER_MAX) next_state = DONE;
                else                            next_state = ISSUE;
            end
            DONE: begin
                px_done    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_x     <= '0;
            z_y     <= '0;
            c_r     <= '0;
            c_i     <= '0;
            w_x     <= '0;
            w_y     <= '0;
            res     <= '0;
            iter    <= '0;
            tmo     <= '0;
            escaped <= 1'b0;
            err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (px_start) begin
                        z_x     <= px_x;
                        z_y     <= px_y;
                        c_r     <= px_cr;
                        c_i     <= px_ci;
                        iter    <= '0;
                        tmo     <= '0;
                        escaped <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                WAIT: begin
                    if (step_done) begin
                        w_x  <= step_wx;
                        w_y  <= step_wy;
                        res  <= step_res;
                        iter <= iter + 1'b1;
                        tmo  <= '0;
                    end else if (tmo == TMO_LAST) begin
                        err <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                CHECK: begin
                    if (escape) begin
                        escaped <= 1'b1;
                    end else if (iter != ITER_MAX) begin
                        z_x <= w_x;
                        z_y <= w_y;
                    end
                end
                default: ;
            endcase
        end
    end

    assign px_iter    = iter;
    assign px_escaped = escaped;
    assign px_err     = err;
    assign step_x     = z_x;
    assign step_y     = z_y;
    assign step_cr    = c_r;
    assign step_ci    = c_i;

endmodule

// File: tb/tb_julia_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_julia_iter_ctrl
//   Self-checking bench for julia_iter_ctrl. A behavioural step engine
//   answers after a programmable number of enabled cycles. It can compute
//   z^2+c, return forced values, or never answer. A table of pixel records
//   with hand-computed results is run first. Hand-written sequences then
//   cover start pulses while busy or done, and a reset taken mid-pixel.
// ---------------------------------------------------------------------------
module tb_julia_iter_ctrl;

    localparam int MODE_CALC  = 0;
    localparam int MODE_NEVER = 1;
    localparam int MODE_FORCE = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               px_start = 1'b0;
    logic signed [31:0] px_x = '0, px_y = '0, px_cr = '0, px_ci = '0;
    logic               px_busy, px_done, px_escaped, px_err, step_en;
    logic [7:0]         px_iter;
    logic signed [31:0] step_x, step_y, step_cr, step_ci;
    logic               step_done = 1'b0;
    logic signed [31:0] step_wx = '0, step_wy = '0, step_res = '0;

    julia_iter_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .px_start   (px_start),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_cr      (px_cr),
        .px_ci      (px_ci),
        .px_busy    (px_busy),
        .px_done    (px_done),
        .px_iter    (px_iter),
        .px_escaped (px_escaped),
        .px_err     (px_err),
        .step_en    (step_en),
        .step_x     (step_x),
        .step_y     (step_y),
        .step_cr    (step_cr),
        .step_ci    (step_ci),
        .step_done  (step_done),
        .step_wx    (step_wx),
        .step_wy    (step_wy),
        .step_res   (step_res)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural step engine ----------------
    int          eng_mode = MODE_CALC;
    int          eng_lat  = 2;
    int          en_cnt   = 0;
    int          f_wx = 0, f_wy = 0, f_res = 0;
    longint      xx, yy, wx64, wy64;

    always @(negedge clk) begin
        if (!step_en) begin
            en_cnt    = 0;
            step_done = 1'b0;
        end else begin
            en_cnt = en_cnt + 1;
            if (eng_mode != MODE_NEVER && en_cnt >= eng_lat) begin
                step_done = 1'b1;
                if (eng_mode == MODE_FORCE) begin
                    step_wx  = f_wx;
                    step_wy  = f_wy;
                    step_res = f_res;
                end else begin
                    xx       = longint'(step_x);
                    yy       = longint'(step_y);
                    wx64     = (xx * xx - yy * yy) / 1000 + longint'(step_cr);
                    wy64     = (2 * xx * yy) / 1000 + longint'(step_ci);
                    step_wx  = wx64[31:0];
                    step_wy  = wy64[31:0];
                    step_res = 32'(wx64 * wx64 + wy64 * wy64);
                end
            end else begin
                step_done = 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(px_busy),    0);
        check({tag, "_done"},  64'(px_done),    0);
        check({tag, "_iter"},  64'(px_iter),    0);
        check({tag, "_esc"},   64'(px_escaped), 0);
        check({tag, "_err"},   64'(px_err),     0);
        check({tag, "_en"},    64'(step_en),    0);
        check({tag, "_zxy"},   64'({step_x, step_y}),   0);
        check({tag, "_cri"},   64'({step_cr, step_ci}), 0);
    endtask

    typedef struct {
        int x, y, cr, ci;
        int mode, lat;
        int fx, fy, fres;
        int exp_iter, exp_esc, exp_err, exp_cycles;
    } vec_t;

    vec_t vecs[10];

    // Starts one pixel from a negedge and follows it to px_done.
    // mid_start pulses px_start with other coordinates while busy.
    // start_in_done pulses px_start during the px_done cycle.
    task automatic run_vec(input vec_t v, input string tag,
                           input bit mid_start, input bit start_in_done);
        int cycles, low_run, gap_bad;
        bit seen;
        eng_mode = v.mode;
        eng_lat  = v.lat;
        f_wx = v.fx; f_wy = v.fy; f_res = v.fres;
        px_x = v.x; px_y = v.y; px_cr = v.cr; px_ci = v.ci;
        px_start = 1'b1;
        @(negedge clk);
        px_start = 1'b0;
        // Scramble inputs: the pixel must run on latched values.
        px_x = 32'sd777; px_y = -32'sd777; px_cr = 32'sd55; px_ci = -32'sd55;
        cycles = 0; low_run = 0; gap_bad = 0; seen = 1'b0;
        for (int t = 0; t < 3000 && !seen; t++) begin
            if (px_busy) cycles++;
            if (step_en) begin
                if (low_run > 1) gap_bad++;
                low_run = 0;
            end else if (px_busy) begin
                low_run++;
            end
            if (px_done) begin
                seen = 1'b1;
            end else begin
                if (mid_start) begin
                    px_start = (t == 3);
                    px_x = 32'sd3000; px_y = 0; px_cr = 0; px_ci = 0;
                end
                @(negedge clk);
            end
        end
        px_start = 1'b0;
        check({tag, "_done_seen"}, 64'(seen),       1);
        check({tag, "_iter"},      64'(px_iter),    64'(v.exp_iter));
        check({tag, "_escaped"},   64'(px_escaped), 64'(v.exp_esc));
        check({tag, "_err"},       64'(px_err),     64'(v.exp_err));
        check({tag, "_cycles"},    64'(cycles),     64'(v.exp_cycles));
        check({tag, "_en_gap"},    64'(gap_bad),    0);
        if (start_in_done) px_start = 1'b1;
        @(negedge clk);
        px_start = 1'b0;
        check({tag, "_pulse"},     64'(px_done),    0);
        check({tag, "_idle"},      64'(px_busy),    0);
        check({tag, "_held"},      64'(px_iter),    64'(v.exp_iter));
    endtask

    initial begin
        //                x     y     cr    ci  mode        lat fx    fy     fres     it esc err cyc
        vecs[0] = '{0,    0,    0,    0,  MODE_CALC,  2,  0,    0,     0,       255, 0, 0, 766};
        vecs[1] = '{3000, 0,    0,    0,  MODE_CALC,  2,  0,    0,     0,       1,   1, 0, 4};
        vecs[2] = '{0,    0,    0,    0,  MODE_NEVER, 2,  0,    0,     0,       0,   0, 1, 66};
        vecs[3] = '{0,    0,    0,    0,  MODE_FORCE, 2,  10,   10,    -5,      1,   1, 0, 4};
        vecs[4] = '{0,    0,    1000, 0,  MODE_CALC,  5,  0,    0,     0,       3,   1, 0, 19};
        vecs[5] = '{0,    0,    0,    0,  MODE_FORCE, 2,  int'(32'h8000_0000), 0, 0, 1, 1, 0, 4};
        vecs[6] = '{0,    0,    0,    0,  MODE_FORCE, 2,  2000, -2000, 4000000, 255, 0, 0, 766};
        vecs[7] = '{0,    0,    0,    0,  MODE_FORCE, 2,  2001, 0,     0,       1,   1, 0, 4};
        vecs[8] = '{0,    0,    0,    0,  MODE_FORCE, 2,  0,    -2001, 0,       1,   1, 0, 4};
        vecs[9] = '{0,    0,    0,    0,  MODE_FORCE, 2,  0,    0,     4000001, 1,   1, 0, 4};

        // Reset state.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0, 1'b0);
        end

        // Start pulses while busy and during px_done are ignored; the next
        // start after completion picks up new coordinates.
        run_vec(vecs[4], "busy_start", 1'b1, 1'b1);
        run_vec(vecs[1], "after_busy", 1'b0, 1'b0);

        // Latched c must reach the engine unchanged.
        px_x = 32'sd100; px_y = 0; px_cr = 32'sd1000; px_ci = -32'sd7;
        eng_mode = MODE_CALC; eng_lat = 5;
        px_start = 1'b1;
        @(negedge clk);
        px_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pre_en",  64'(step_en), 1);
        check("rst_pre_zx",  64'(step_x),  100);
        check("rst_pre_cr",  64'(step_cr), 1000);
        check("rst_pre_ci",  64'(step_ci), -7);

        // Reset in WAIT clears outputs asynchronously and aborts the pixel.
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        begin
            int done_in_rst;
            done_in_rst = 0;
            repeat (3) begin
                @(negedge clk);
                if (px_done || px_busy) done_in_rst++;
            end
            check("rst_no_done", 64'(done_in_rst), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[1], "post_rst", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
